// File: rtl/pipe_pal_ingress_pkg.sv
// pipe_pal_ingress_pkg: shared widths and helpers for the pipe_pal ingress path.
// Imported by the stream interface, the storage array and the ingress top.
package pipe_pal_ingress_pkg;

    localparam int W_DATA_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of the occupancy count that pipe_pal also consumes.
    localparam int LVL_W = clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/pipe_pal_ingress_if.sv
// pipe_pal_ingress_if: valid/ready/data word stream.
// The master drives valid/data, the slave drives ready.
interface pipe_pal_ingress_if
    import pipe_pal_ingress_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF
);
    logic              valid;
    logic              ready;
    logic [W_DATA-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_pal_ingress_ram.sv
// pipe_pal_ingress_ram: DEPTH x W_DATA storage, one write port and one
// asynchronous read port. The array itself is never reset.
module pipe_pal_ingress_ram
    import pipe_pal_ingress_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PW     = 3
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PW-1:0]     i_waddr,
    input  logic [W_DATA-1:0] i_wdata,
    input  logic [PW-1:0]     i_raddr,
    output logic [W_DATA-1:0] o_rdata
);
    logic [W_DATA-1:0] r_mem [DEPTH];

    // Write the accepted word into its slot.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pipe_pal_ingress.sv
// pipe_pal_ingress: elastic FWFT buffer in front of pipe_pal.
// All handshake outputs come from flops, so producer and consumer never chain.
module pipe_pal_ingress
    import pipe_pal_ingress_pkg::*;
#(
    parameter int W_DATA   = W_DATA_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    pipe_pal_ingress_if.slave         s,
    pipe_pal_ingress_if.master        m,
    output logic [clog2(DEPTH+1)-1:0] o_level,
    output logic                      o_almost_full
);
    localparam int LW = clog2(DEPTH + 1);
    localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] L_AF    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] L_ONE   = LW'(1);
    localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_s_ready;
    logic              r_m_valid;
    logic              r_af;

    logic              w_push;
    logic              w_pop;
    logic [LW-1:0]     w_level_nxt;
    logic [W_DATA-1:0] w_rd_data;

    assign w_push = s.valid & r_s_ready;
    assign w_pop  = r_m_valid & m.ready;

    // Occupancy after this edge's transfers (flush handled in the flop block).
    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + L_ONE;
            2'b01:   w_level_nxt = r_level - L_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointers, level and the registered flags; reset beats flush beats transfers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_af      <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_af      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + P_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + P_ONE;
            end
            r_level   <= w_level_nxt;
            r_s_ready <= (w_level_nxt < L_DEPTH);
            r_m_valid <= (w_level_nxt != '0);
            r_af      <= (w_level_nxt >= L_AF);
        end
    end

    pipe_pal_ingress_ram #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push & ~i_flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (s.data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign s.ready       = r_s_ready;
    assign m.valid       = r_m_valid;
    assign m.data        = w_rd_data;
    assign o_level       = r_level;
    assign o_almost_full = r_af;
endmodule

// File: tb/tb_pipe_pal_ingress.sv
// tb_pipe_pal_ingress: directed checks of the ingress buffer.
// Inputs change 1 ns after a rising edge; outputs are read there too.
module tb_pipe_pal_ingress;
    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] level;
    logic       af;

    int n_vec;
    int n_err;

    pipe_pal_ingress_if #(.W_DATA(32)) s_if ();
    pipe_pal_ingress_if #(.W_DATA(32)) m_if ();

    pipe_pal_ingress #(
        .W_DATA   (32),
        .DEPTH    (8),
        .AF_LEVEL (6)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .s             (s_if),
        .m             (m_if),
        .o_level       (level),
        .o_almost_full (af)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int nin;
        int nout;
        int cyc;
        logic pu;
        logic po;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        flush = 1'b0;
        s_if.valid = 1'b0;
        s_if.data = '0;
        m_if.ready = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(level), 0);
        chk("rst_mvalid", 32'(m_if.valid), 0);
        chk("rst_sready", 32'(s_if.ready), 1);
        chk("rst_af", 32'(af), 0);
        rst = 1'b0;
        tick();

        // 1: three pushes, head visible one cycle after the first
        s_if.valid = 1'b1;
        s_if.data = 32'h11;
        chk("t1_no_bypass", 32'(m_if.valid), 0);
        tick();
        chk("t1_mvalid", 32'(m_if.valid), 1);
        chk("t1_mdata", m_if.data, 32'h11);
        s_if.data = 32'h22;
        tick();
        s_if.data = 32'h33;
        tick();
        s_if.valid = 1'b0;
        chk("t1_level", 32'(level), 3);
        chk("t1_head", m_if.data, 32'h11);

        // 2: fill to eight, almost_full at six, ninth refused
        s_if.valid = 1'b1;
        for (int i = 4; i <= 8; i++) begin
            s_if.data = 32'(i * 16 + i);
            tick();
            if (i == 5) chk("t2_af_lvl5", 32'(af), 0);
            if (i == 6) chk("t2_af_lvl6", 32'(af), 1);
        end
        chk("t2_full_level", 32'(level), 8);
        chk("t2_sready", 32'(s_if.ready), 0);
        s_if.data = 32'h99;
        tick();
        tick();
        chk("t2_ninth_level", 32'(level), 8);

        // 3: full, push and pop offered together -> pop only
        m_if.ready = 1'b1;
        chk("t3_head", m_if.data, 32'h11);
        tick();
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        chk("t3_level", 32'(level), 7);
        chk("t3_sready", 32'(s_if.ready), 1);
        chk("t3_af", 32'(af), 1);

        // drain remaining seven in order
        m_if.ready = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("t3_drain", m_if.data, 32'(i * 16 + i));
            tick();
        end
        m_if.ready = 1'b0;
        chk("t3_empty_level", 32'(level), 0);
        chk("t3_empty_mvalid", 32'(m_if.valid), 0);

        // 4: random-handshake stream of 0..19
        nin = 0;
        nout = 0;
        cyc = 0;
        while (nout < 20 && cyc < 500) begin
            s_if.valid = (nin < 20) && ($urandom_range(0, 1) == 1);
            s_if.data = 32'(nin);
            m_if.ready = ($urandom_range(0, 1) == 1);
            pu = s_if.valid & s_if.ready;
            po = m_if.valid & m_if.ready;
            if (po) chk("t4_order", m_if.data, 32'(nout));
            tick();
            if (pu) nin++;
            if (po) nout++;
            cyc++;
        end
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        chk("t4_count", 32'(nout), 20);
        chk("t4_level", 32'(level), 0);

        // 5: flush at level five overrides push and pop
        s_if.valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.data = 32'hA0 + 32'(i);
            tick();
        end
        chk("t5_level5", 32'(level), 5);
        flush = 1'b1;
        s_if.data = 32'hEE;
        m_if.ready = 1'b1;
        tick();
        flush = 1'b0;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        chk("t5_level", 32'(level), 0);
        chk("t5_mvalid", 32'(m_if.valid), 0);
        chk("t5_sready", 32'(s_if.ready), 1);
        s_if.valid = 1'b1;
        s_if.data = 32'h5A;
        tick();
        s_if.valid = 1'b0;
        chk("t5_post_level", 32'(level), 1);
        chk("t5_post_data", m_if.data, 32'h5A);
        m_if.ready = 1'b1;
        tick();
        m_if.ready = 1'b0;

        // 6: async reset between edges at level four
        s_if.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_if.data = 32'hC0 + 32'(i);
            tick();
        end
        s_if.valid = 1'b0;
        chk("t6_level4", 32'(level), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_mvalid", 32'(m_if.valid), 0);
        chk("t6_async_level", 32'(level), 0);
        chk("t6_async_sready", 32'(s_if.ready), 1);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_level", 32'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
